// File: rtl/input_port_writer_if.sv
// rtl/input_port_writer_if.sv - line-side word stream into the input port writer
interface input_port_writer_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/input_port_writer.sv
// rtl/input_port_writer.sv - writes accepted non-zero line words into the input RAM
// and publishes the next free address and occupancy to the scheduler.
module input_port_writer #(
  parameter logic [11:0] ALMOST_FULL_TH = 12'd4032,
  parameter logic [11:0] LAST_ADDR      = 12'd4095
) (
  input  logic                clk,
  input  logic                rst_n,
  input_port_writer_if.slave  in_if,
  output logic [31:0]         ram_wr_data,
  output logic [11:0]         ram_wr_add,
  output logic                ram_wren,
  output logic [11:0]         input_ram_wr_add,
  input  logic [11:0]         input_ram_rd_add,
  output logic [11:0]         occupancy,
  output logic                almost_full,
  output logic [15:0]         null_count,
  output logic                ptr_err
);

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  localparam logic [11:0] LAST_M1 = LAST_ADDR - 12'd1;

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        xfer, is_null, rd_ahead;
  logic [11:0] ptr_next;

  assign in_if.in_ready = in_ready_q;
  assign ram_wren       = (state_q == WRITE);

  always_comb begin
    // The pointer advances as the WRITE cycle ends, so a word accepted on that
    // same edge lands at the already-advanced address.
    ptr_next   = input_ram_wr_add + {11'd0, (state_q == WRITE)};
    xfer       = in_if.in_valid && in_ready_q && (state_q != FULL);
    is_null    = (in_if.in_data == 32'd0);
    state_d    = IDLE;
    in_ready_d = 1'b1;
    if (state_q == FULL || ptr_next == LAST_ADDR)
      state_d = FULL;
    else if (xfer && !is_null)
      state_d = WRITE;
    // Stop accepting once the word in flight claims the last usable address.
    if (state_d == FULL || (xfer && ptr_next == LAST_M1))
      in_ready_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      in_ready_q       <= 1'b0;
      ram_wr_add       <= 12'd0;
      ram_wr_data      <= 32'd0;
      input_ram_wr_add <= 12'd1;
      null_count       <= 16'd0;
      ptr_err          <= 1'b0;
    end else begin
      state_q          <= state_d;
      in_ready_q       <= in_ready_d;
      input_ram_wr_add <= ptr_next;
      if (xfer && !is_null) begin
        ram_wr_add  <= ptr_next;
        ram_wr_data <= in_if.in_data;
      end
      if (xfer && is_null && null_count != 16'hFFFF)
        null_count <= null_count + 16'd1;
      if (rd_ahead)
        ptr_err <= 1'b1;
    end
  end

  always_comb begin
    rd_ahead    = (input_ram_rd_add > input_ram_wr_add);
    occupancy   = rd_ahead ? 12'd0 : (input_ram_wr_add - input_ram_rd_add);
    almost_full = (occupancy >= ALMOST_FULL_TH);
  end

endmodule

// File: tb/tb_input_port_writer.sv
// tb/tb_input_port_writer.sv - directed self-checking bench for input_port_writer
module tb_input_port_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ram_wr_data;
  logic [11:0] ram_wr_add;
  logic        ram_wren;
  logic [11:0] input_ram_wr_add;
  logic [11:0] input_ram_rd_add = 12'd0;
  logic [11:0] occupancy;
  logic        almost_full;
  logic [15:0] null_count;
  logic        ptr_err;

  int checks = 0;
  int errors = 0;

  input_port_writer_if bus ();

  input_port_writer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_if            (bus),
    .ram_wr_data      (ram_wr_data),
    .ram_wr_add       (ram_wr_add),
    .ram_wren         (ram_wren),
    .input_ram_wr_add (input_ram_wr_add),
    .input_ram_rd_add (input_ram_rd_add),
    .occupancy        (occupancy),
    .almost_full      (almost_full),
    .null_count       (null_count),
    .ptr_err          (ptr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 32'd0;
    input_ram_rd_add = 12'd0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_wren", 32'(ram_wren), 0);
    chk("rst_wr_add", 32'(ram_wr_add), 0);
    chk("rst_wr_data", ram_wr_data, 0);
    chk("rst_ptr", 32'(input_ram_wr_add), 1);
    chk("rst_null", 32'(null_count), 0);
    chk("rst_ptr_err", 32'(ptr_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(bus.in_ready), 1);
  endtask

  int wrcount, nacc;
  logic [11:0] last_add;
  logic [31:0] last_data;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 32'd0;

    // two consecutive words
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = 32'h11;
    @(negedge clk);
    chk("w1_wren", 32'(ram_wren), 1);
    chk("w1_add", 32'(ram_wr_add), 1);
    chk("w1_data", ram_wr_data, 32'h11);
    bus.in_data = 32'h22;
    @(negedge clk);
    chk("w2_wren", 32'(ram_wren), 1);
    chk("w2_add", 32'(ram_wr_add), 2);
    chk("w2_data", ram_wr_data, 32'h22);
    chk("w2_ptr", 32'(input_ram_wr_add), 2);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("w3_wren", 32'(ram_wren), 0);
    chk("w3_ptr", 32'(input_ram_wr_add), 3);
    chk("hold_add", 32'(ram_wr_add), 2);
    chk("hold_data", ram_wr_data, 32'h22);

    // zero word discarded, then a word with destination bits 3
    do_reset();
    bus.in_valid = 1'b1; bus.in_data = 32'h0;
    @(negedge clk);
    chk("z_wren", 32'(ram_wren), 0);
    chk("z_null", 32'(null_count), 1);
    bus.in_data = 32'h3;
    @(negedge clk);
    chk("z3_wren", 32'(ram_wren), 1);
    chk("z3_add", 32'(ram_wr_add), 1);
    chk("z3_data", ram_wr_data, 32'h3);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("z3_ptr", 32'(input_ram_wr_add), 2);
    chk("z3_null", 32'(null_count), 1);

    // occupancy and pointer error
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 99; i++) begin
      bus.in_data = 32'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("occ_ptr", 32'(input_ram_wr_add), 100);
    input_ram_rd_add = 12'd36; #1;
    chk("occ_64", 32'(occupancy), 64);
    chk("af_64", 32'(almost_full), 0);
    input_ram_rd_add = 12'd100; #1;
    chk("occ_eq", 32'(occupancy), 0);
    input_ram_rd_add = 12'd101; #1;
    chk("occ_ahead", 32'(occupancy), 0);
    @(negedge clk);
    chk("ptr_err_set", 32'(ptr_err), 1);
    input_ram_rd_add = 12'd0;
    @(negedge clk);
    chk("ptr_err_sticky", 32'(ptr_err), 1);
    chk("occ_100", 32'(occupancy), 100);

    // reset during the WRITE cycle of address 5
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.in_data = 32'h50 + 32'(i);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_wren", 32'(ram_wren), 1);
    chk("pre_rst_add", 32'(ram_wr_add), 5);
    #1 rst_n = 1'b0;
    #1;
    chk("async_wren", 32'(ram_wren), 0);
    chk("async_ptr", 32'(input_ram_wr_add), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_ptr", 32'(input_ram_wr_add), 1);
    chk("post_null", 32'(null_count), 0);
    chk("post_ready", 32'(bus.in_ready), 1);

    // fill to FULL with in_valid held high
    do_reset();
    wrcount = 0; nacc = 0; last_add = '0; last_data = '0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'd1;
    for (int c = 0; c < 4120; c++) begin
      if (bus.in_ready) nacc++;
      @(negedge clk);
      if (ram_wren) begin
        wrcount++;
        last_add = ram_wr_add;
        last_data = ram_wr_data;
      end
      bus.in_data = 32'(nacc + 1);
    end
    chk("full_accepted", 32'(nacc), 4094);
    chk("full_writes", 32'(wrcount), 4094);
    chk("full_last_add", 32'(last_add), 4094);
    chk("full_last_data", last_data, 4094);
    chk("full_ptr", 32'(input_ram_wr_add), 4095);
    chk("full_ready", 32'(bus.in_ready), 0);
    chk("full_state", 32'(dut.state_q), 2);
    bus.in_data = 32'd0;
    repeat (3) @(negedge clk);
    chk("full_wren", 32'(ram_wren), 0);
    chk("full_null", 32'(null_count), 0);
    chk("full_add_hold", 32'(ram_wr_add), 4094);
    input_ram_rd_add = 12'd0; #1;
    chk("af_4095", 32'(almost_full), 1);
    input_ram_rd_add = 12'd63; #1;
    chk("occ_4032", 32'(occupancy), 4032);
    chk("af_4032", 32'(almost_full), 1);
    input_ram_rd_add = 12'd64; #1;
    chk("af_4031", 32'(almost_full), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
